// File: rtl/mnist_image_streamer.sv
// mnist_image_streamer: quantizes 64 raster pixels to 2 bits, packs them
// four per byte, then drives the inference core and returns its result.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   pix_valid/pix_data/pix_ready    8-bit pixel input stream
//   core_start/core_pixels          start pulse + 16 packed bytes to core
//   core_done/core_prediction       completion + digit from core
//   result_valid/result_ready       result handshake
//   result_digit/result_timeout     digit (4'hF on timeout), error flag
//   busy                            high outside COLLECT
module mnist_image_streamer #(
  parameter logic [7:0]  THRESH1 = 8'd64,
  parameter logic [7:0]  THRESH2 = 8'd128,
  parameter logic [7:0]  THRESH3 = 8'd192,
  parameter logic [15:0] TIMEOUT = 16'd8191
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       pix_ready,
  output logic       core_start,
  output logic [7:0] core_pixels,
  input  logic       core_done,
  input  logic [3:0] core_prediction,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [3:0] result_digit,
  output logic       result_timeout,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_START,
    S_STREAM,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_buf [16];
  logic [5:0]  r_pix_cnt;
  logic [5:0]  w_pix_cnt_nxt;
  logic [3:0]  r_byte_cnt;
  logic [3:0]  w_byte_cnt_nxt;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_cnt_nxt;
  logic        r_pix_ready;
  logic        r_core_start;
  logic        w_core_start_nxt;
  logic [7:0]  r_core_pixels;
  logic [7:0]  w_core_pixels_nxt;
  logic        r_result_valid;
  logic        w_result_valid_nxt;
  logic [3:0]  r_result_digit;
  logic [3:0]  w_result_digit_nxt;
  logic        r_result_timeout;
  logic        w_result_timeout_nxt;
  logic        r_busy;
  logic        w_accept;
  logic [1:0]  w_q;

  assign w_accept = (r_state == S_COLLECT)
                  && pix_valid && r_pix_ready;

  always_comb begin
    w_q = 2'd3;
    if (pix_data < THRESH1) begin
      w_q = 2'd0;
    end else if (pix_data < THRESH2) begin
      w_q = 2'd1;
    end else if (pix_data < THRESH3) begin
      w_q = 2'd2;
    end
  end

  // Buffer is deliberately not reset: every byte is rewritten each frame.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_pix_cnt[5:2]][{r_pix_cnt[1:0], 1'b0} +: 2] <= w_q;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_pix_cnt_nxt        = r_pix_cnt;
    w_byte_cnt_nxt       = r_byte_cnt;
    w_wait_cnt_nxt       = r_wait_cnt;
    w_core_start_nxt     = 1'b0;
    w_core_pixels_nxt    = 8'd0;
    w_result_valid_nxt   = r_result_valid;
    w_result_digit_nxt   = r_result_digit;
    w_result_timeout_nxt = r_result_timeout;
    unique case (r_state)
      S_COLLECT: begin
        if (w_accept) begin
          w_pix_cnt_nxt = r_pix_cnt + 6'd1;
          if (r_pix_cnt == 6'd63) begin
            w_state_nxt      = S_START;
            w_core_start_nxt = 1'b1;
          end
        end
      end
      S_START: begin
        // Preload byte 0 so it is on the bus the cycle after start.
        w_core_pixels_nxt = r_buf[0];
        w_byte_cnt_nxt    = 4'd0;
        w_state_nxt       = S_STREAM;
      end
      S_STREAM: begin
        if (r_byte_cnt == 4'd15) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = 16'd0;
        end else begin
          w_core_pixels_nxt = r_buf[r_byte_cnt + 4'd1];
          w_byte_cnt_nxt    = r_byte_cnt + 4'd1;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          w_result_digit_nxt   = core_prediction;
          w_result_timeout_nxt = 1'b0;
          w_result_valid_nxt   = 1'b1;
          w_state_nxt          = S_RESULT;
        end else if (r_wait_cnt == TIMEOUT) begin
          w_result_digit_nxt   = 4'hF;
          w_result_timeout_nxt = 1'b1;
          w_result_valid_nxt   = 1'b1;
          w_state_nxt          = S_RESULT;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
      end
      S_RESULT: begin
        // Hold off until the core drops done so it is idle on restart.
        if (result_ready && !core_done) begin
          w_result_valid_nxt = 1'b0;
          w_pix_cnt_nxt      = 6'd0;
          w_state_nxt        = S_COLLECT;
        end
      end
      default: begin
        w_state_nxt = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_COLLECT;
      r_pix_cnt        <= 6'd0;
      r_byte_cnt       <= 4'd0;
      r_wait_cnt       <= 16'd0;
      r_pix_ready      <= 1'b1;
      r_busy           <= 1'b0;
      r_core_start     <= 1'b0;
      r_core_pixels    <= 8'd0;
      r_result_valid   <= 1'b0;
      r_result_digit   <= 4'd0;
      r_result_timeout <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_pix_cnt        <= w_pix_cnt_nxt;
      r_byte_cnt       <= w_byte_cnt_nxt;
      r_wait_cnt       <= w_wait_cnt_nxt;
      r_pix_ready      <= (w_state_nxt == S_COLLECT);
      r_busy           <= (w_state_nxt != S_COLLECT);
      r_core_start     <= w_core_start_nxt;
      r_core_pixels    <= w_core_pixels_nxt;
      r_result_valid   <= w_result_valid_nxt;
      r_result_digit   <= w_result_digit_nxt;
      r_result_timeout <= w_result_timeout_nxt;
    end
  end

  assign pix_ready      = r_pix_ready;
  assign busy           = r_busy;
  assign core_start     = r_core_start;
  assign core_pixels    = r_core_pixels;
  assign result_valid   = r_result_valid;
  assign result_digit   = r_result_digit;
  assign result_timeout = r_result_timeout;

endmodule

// File: tb/tb_mnist_image_streamer.sv
// tb_mnist_image_streamer: directed frames against a default instance
// and a THRESH1=10 / TIMEOUT=100 instance, with byte/result scoreboards.
module tb_mnist_image_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pv;
  logic [7:0] pd;
  logic       rr;
  logic       cd;
  logic [3:0] cp;
  logic       sel;

  always #5 clk = ~clk;

  logic       a_pr, a_cs, a_rv, a_to, a_busy;
  logic [7:0] a_cpx;
  logic [3:0] a_dig;
  logic       b_pr, b_cs, b_rv, b_to, b_busy;
  logic [7:0] b_cpx;
  logic [3:0] b_dig;

  mnist_image_streamer u_dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .pix_valid       (pv & ~sel),
    .pix_data        (pd),
    .pix_ready       (a_pr),
    .core_start      (a_cs),
    .core_pixels     (a_cpx),
    .core_done       (cd & ~sel),
    .core_prediction (cp),
    .result_valid    (a_rv),
    .result_ready    (rr & ~sel),
    .result_digit    (a_dig),
    .result_timeout  (a_to),
    .busy            (a_busy)
  );

  mnist_image_streamer #(
    .THRESH1 (8'd10),
    .TIMEOUT (16'd100)
  ) u_dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .pix_valid       (pv & sel),
    .pix_data        (pd),
    .pix_ready       (b_pr),
    .core_start      (b_cs),
    .core_pixels     (b_cpx),
    .core_done       (cd & sel),
    .core_prediction (cp),
    .result_valid    (b_rv),
    .result_ready    (rr & sel),
    .result_digit    (b_dig),
    .result_timeout  (b_to),
    .busy            (b_busy)
  );

  wire       pr   = sel ? b_pr   : a_pr;
  wire       cs   = sel ? b_cs   : a_cs;
  wire       rv   = sel ? b_rv   : a_rv;
  wire       to   = sel ? b_to   : a_to;
  wire       busy = sel ? b_busy : a_busy;
  wire [7:0] cpx  = sel ? b_cpx  : a_cpx;
  wire [3:0] dig  = sel ? b_dig  : a_dig;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] pix [64];
  logic [7:0] exp_q [$];
  logic [4:0] res_q [$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] quant(input logic [7:0] p,
                                       input logic s);
    logic [7:0] t1;
    t1 = s ? 8'd10 : 8'd64;
    if (p < t1) return 2'd0;
    if (p < 8'd128) return 2'd1;
    if (p < 8'd192) return 2'd2;
    return 2'd3;
  endfunction

  task automatic feed(input int n, input bit bubble);
    int         acc;
    int         ph;
    bit         fire;
    logic [7:0] b;
    acc = 0;
    ph = 0;
    b = 8'd0;
    chk("pix_ready_idle", {15'd0, pr}, 16'd1);
    while (acc < n) begin
      if (bubble && ph[0]) begin
        pv = 1'b0;
      end else begin
        pv = 1'b1;
        pd = pix[acc];
      end
      fire = pv;
      ph++;
      tick;
      if (fire) begin
        b[2*(acc%4) +: 2] = quant(pix[acc], sel);
        if (acc % 4 == 3) exp_q.push_back(b);
        acc++;
      end
    end
    pv = 1'b0;
  endtask

  task automatic stream_check(input bit junk);
    chk("q_size", exp_q.size(), 16'd16);
    chk("start", {15'd0, cs}, 16'd1);
    chk("start_pix", {8'd0, cpx}, 16'd0);
    chk("pr_start", {15'd0, pr}, 16'd0);
    chk("busy_start", {15'd0, busy}, 16'd1);
    for (int k = 0; k < 16; k++) begin
      if (junk) begin
        pv = k[0];
        pd = 8'hAA;
      end
      tick;
      if (exp_q.size() > 0) begin
        chk($sformatf("byte%0d", k), {8'd0, cpx},
            {8'd0, exp_q.pop_front()});
      end
      chk("start_off", {15'd0, cs}, 16'd0);
      chk("pr_stream", {15'd0, pr}, 16'd0);
    end
    tick;
    chk("pix_after", {8'd0, cpx}, 16'd0);
    chk("start_after", {15'd0, cs}, 16'd0);
  endtask

  task automatic done_path(input int delay, input logic [3:0] pred,
                           input bit junk);
    logic [4:0] r;
    rr = 1'b1;
    repeat (delay - 17) begin
      if (junk) begin
        pv = ~pv;
        pd = 8'h55;
      end
      tick;
    end
    chk("valid_pre_done", {15'd0, rv}, 16'd0);
    cd = 1'b1;
    cp = pred;
    res_q.push_back({1'b0, pred});
    tick;
    r = res_q.pop_front();
    chk("valid_done", {15'd0, rv}, 16'd1);
    chk("digit", {12'd0, dig}, {12'd0, r[3:0]});
    chk("timeout_flag", {15'd0, to}, {15'd0, r[4]});
    chk("pr_result", {15'd0, pr}, 16'd0);
    tick;
    cd = 1'b0;
    pv = 1'b0;
    chk("valid_hold_done", {15'd0, rv}, 16'd1);
    tick;
    chk("valid_clear", {15'd0, rv}, 16'd0);
    chk("pr_back", {15'd0, pr}, 16'd1);
    chk("busy_back", {15'd0, busy}, 16'd0);
    rr = 1'b0;
    cp = 4'd0;
  endtask

  task automatic timeout_path(input bit junk);
    logic [4:0] r;
    res_q.push_back({1'b1, 4'hF});
    repeat (100) begin
      if (junk) begin
        pv = ~pv;
        pd = 8'h33;
      end
      tick;
    end
    chk("valid_w100", {15'd0, rv}, 16'd0);
    tick;
    r = res_q.pop_front();
    chk("valid_w101", {15'd0, rv}, 16'd1);
    chk("digit_to", {12'd0, dig}, {12'd0, r[3:0]});
    chk("timeout_set", {15'd0, to}, {15'd0, r[4]});
    pv = 1'b0;
    rr = 1'b1;
    tick;
    chk("valid_clear_to", {15'd0, rv}, 16'd0);
    chk("pr_back_to", {15'd0, pr}, 16'd1);
    rr = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pr"}, {15'd0, pr}, 16'd1);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_cs"}, {15'd0, cs}, 16'd0);
    chk({tag, "_cpx"}, {8'd0, cpx}, 16'd0);
    chk({tag, "_rv"}, {15'd0, rv}, 16'd0);
    chk({tag, "_dig"}, {12'd0, dig}, 16'd0);
    chk({tag, "_to"}, {15'd0, to}, 16'd0);
  endtask

  initial begin
    sel = 1'b0;
    pv = 1'b0;
    pd = 8'd0;
    rr = 1'b0;
    cd = 1'b0;
    cp = 4'd0;
    rst_n = 1'b0;
    repeat (3) tick;
    reset_checks("rst");
    rst_n = 1'b1;
    tick;

    // Ramp frame, slow core, junk pixels while busy.
    for (int i = 0; i < 64; i++) pix[i] = 8'(4 * i);
    feed(64, 1'b0);
    stream_check(1'b1);
    done_path(3763, 4'd7, 1'b1);

    // Threshold edges, back-to-back frame.
    for (int i = 0; i < 64; i++) begin
      case (i % 6)
        0: pix[i] = 8'd63;
        1: pix[i] = 8'd64;
        2: pix[i] = 8'd127;
        3: pix[i] = 8'd128;
        4: pix[i] = 8'd191;
        default: pix[i] = 8'd192;
      endcase
    end
    feed(64, 1'b0);
    stream_check(1'b0);
    done_path(20, 4'd3, 1'b0);

    // Bubbly partial frame aborted by reset.
    for (int i = 0; i < 64; i++) pix[i] = 8'($urandom_range(0, 255));
    feed(30, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 64; i++) pix[i] = 8'($urandom_range(0, 255));
    feed(64, 1'b0);
    stream_check(1'b0);
    done_path(40, 4'd9, 1'b0);

    // Low THRESH1 instance, core never answers.
    sel = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < 32) pix[i] = i[0] ? 8'd10 : 8'd9;
      else pix[i] = 8'($urandom_range(0, 255));
    end
    feed(64, 1'b1);
    stream_check(1'b0);
    timeout_path(1'b1);
    for (int i = 0; i < 64; i++) pix[i] = 8'(255 - 4 * i);
    feed(64, 1'b0);
    stream_check(1'b0);
    timeout_path(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mnist_image_streamer.md
# mnist_image_streamer

Host-side driver for the MNIST inference core. It accepts 64 raster-order 8-bit grayscale pixels over a valid/ready stream and quantizes each pixel to 2 bits. It packs the pixels four per byte, then issues the core's start pulse and streams the 16 packed bytes on consecutive cycles. It waits for the core's done, then presents the prediction, or a timeout error, on a result valid/ready handshake.

## Interface
- THRESH1, default 64: pixel < THRESH1 quantizes to 0.
- THRESH2, default 128: THRESH1 ≤ pixel < THRESH2 quantizes to 1.
- THRESH3, default 192: THRESH2 ≤ pixel < THRESH3 quantizes to 2; pixel ≥ THRESH3 quantizes to 3.
- TIMEOUT, default 8191: maximum WAIT cycles before declaring an error. Width 16.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  input pixel valid.
- pix_data  in  8  grayscale pixel, raster order, pixel 0 first.
- pix_ready  out  1  streamer can accept a pixel.
- core_start  out  1  start pulse to inference core (registered).
- core_pixels  out  8  packed bytes to core (registered). Bits [1:0] = px 4k, [3:2] = 4k+1, [5:4] = 4k+2, [7:6] = 4k+3.
- core_done  in  1  inference complete from core.
- core_prediction  in  4  core's predicted digit.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- result_digit  out  4  prediction; 4'hF on timeout.
- result_timeout  out  1  result is a timeout error.
- busy  out  1  high in every state except COLLECT.

## Operation
- State machine, in order: COLLECT, START, STREAM, WAIT, RESULT.
- Storage: 16×8-bit packed buffer, 6-bit pixel counter, 4-bit byte counter, 16-bit wait counter.
- COLLECT:
  - pix_ready = 1.
  - On pix_valid && pix_ready, quantize pix_data with unsigned compares, write to buffer byte cnt[5:2] at bits 2·cnt[1:0]+1 : 2·cnt[1:0], then increment cnt.
  - On the accept where cnt == 63, go to START. pix_ready is low from the next cycle.
- START:
  - core_start = 1 and core_pixels = 0 for exactly one cycle.
  - Go to STREAM with byte counter = 0.
- STREAM:
  - core_pixels = buffer[k] for k = 0..15 on 16 consecutive cycles. core_start = 0.
  - After k = 15, go to WAIT with wait counter = 0 and core_pixels = 0.
- WAIT:
  - If core_done = 1: latch core_prediction into result_digit, set result_timeout = 0, go to RESULT.
  - Else if the wait counter == TIMEOUT: set result_digit = 4'hF, result_timeout = 1, go to RESULT.
  - Otherwise increment the wait counter.
  - If done and timeout occur in the same cycle, done wins.
- RESULT:
  - result_valid = 1; result_digit and result_timeout are held stable.
  - On result_ready && core_done == 0, clear result_valid, reset cnt, go to COLLECT.
  - result_ready while core_done is still high is ignored, so the core is back in its idle state before the next start.
- core_start never asserts outside START, so the core is never retriggered.
- pix_valid outside COLLECT is ignored, with no side effects.
- Buffer contents are not cleared; every byte is overwritten each frame.

## Timing
- Reset, asynchronous: state COLLECT, counters 0, pix_ready 1, busy 0, core_start 0, core_pixels 0, result_valid 0, result_digit 0, result_timeout 0. The buffer is not reset.
- A reset mid-frame discards all partial data. The next accepted pixel is pixel 0.
- Throughput in COLLECT: one pixel per cycle while pix_valid is held high.
- Accept of pixel 63 at cycle T:
  - core_start high during T+1.
  - core_pixels = byte 0 during T+2 through byte 15 during T+17.
  - WAIT from T+18.
- The core samples start at T+1 and bytes at T+2..T+17; this alignment is mandatory.
- core_done seen high at cycle D: result_valid high from D+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Full frame, pixel i = 4·i (values 0..252): buffer bytes match the quantization. With default thresholds, byte 0 = 8'h00 and byte 15 = 8'hFF. core_start is a single cycle, and the 16 bytes are back-to-back starting the cycle after start.
- Threshold edges: pixels 63, 64, 127, 128, 191, 192 quantize to 0, 1, 1, 2, 2, 3. With THRESH1 = 10, pixel 10 quantizes to 1.
- Core model asserts done 3763 cycles after start with prediction 7, holding done 2 cycles: result_valid = 1, result_digit = 7, result_timeout = 0. result_ready held high is honored only once core_done = 0.
- Core never asserts done, with TIMEOUT = 100: result_valid rises 101 cycles after WAIT entry, result_digit = 4'hF, result_timeout = 1. A new frame is then accepted after result_ready.
- Bubbly input, pix_valid toggling 1/0, then reset asserted after 30 pixels: outputs return to reset values immediately. A following clean 64-pixel frame streams the correct bytes.
- pix_valid pulses during STREAM/WAIT/RESULT: pix_ready = 0, no buffer change, and the next frame is unaffected. Two frames run back-to-back yield two correct results.
